// File: rtl/div_pkg.sv
// Shared types and default widths for the iterative divider.
package div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } t_div_state;

    localparam int DEF_DATA_LEN = 32;
    localparam int DEF_TAG_W    = 8;

endpackage

// File: rtl/iter_divider_if.sv
// Request/response handshake bundle between a requester and iter_divider.
interface iter_divider_if
    import div_pkg::*;
#(
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int TAG_W    = DEF_TAG_W
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] in_a;
    logic [DATA_LEN-1:0] in_b;
    logic                in_signed;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] out_quot;
    logic [DATA_LEN-1:0] out_rem;
    logic [TAG_W-1:0]    out_tag;
    logic                out_div0;

    modport master (
        output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_quot, out_rem, out_tag, out_div0
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        output in_ready, out_valid, out_quot, out_rem, out_tag, out_div0
    );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and produces one quotient bit.
module div_step #(
    parameter int DATA_LEN = 32
) (
    input  logic [DATA_LEN-1:0] rem,
    input  logic [DATA_LEN-1:0] quo,
    input  logic [DATA_LEN-1:0] dvs,
    output logic [DATA_LEN-1:0] rem_next,
    output logic [DATA_LEN-1:0] quo_next
);
    logic [DATA_LEN:0] trial;
    logic [DATA_LEN:0] diff;
    logic              qbit;

    // rem < dvs holds between steps, so the extra top bit of diff is its sign
    assign trial    = {rem, quo[DATA_LEN-1]};
    assign diff     = trial - {1'b0, dvs};
    assign qbit     = ~diff[DATA_LEN];
    assign rem_next = qbit ? diff[DATA_LEN-1:0] : trial[DATA_LEN-1:0];
    assign quo_next = {quo[DATA_LEN-2:0], qbit};
endmodule

// File: rtl/iter_divider.sv
// Fixed-latency signed/unsigned restoring divider with valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for a request
//   PREP  | form operand magnitudes and result signs
//   ITER  | DATA_LEN shift-subtract steps
//   FIX   | apply sign correction / divide-by-zero result
//   DONE  | result held until out_ready
module iter_divider
    import div_pkg::*;
#(
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int TAG_W    = DEF_TAG_W
) (
    input  logic          clk,
    input  logic          reset,
    iter_divider_if.slave bus,
    output logic          busy
);
    localparam int CNT_W = $clog2(DATA_LEN + 1);

    t_div_state state_q;
    t_div_state state_d;
    logic       can_accept;
    logic       accept;

    logic [CNT_W-1:0]    cnt;
    logic [DATA_LEN-1:0] a_q;
    logic [DATA_LEN-1:0] b_q;
    logic                sgn_q;
    logic [TAG_W-1:0]    tag_q;
    logic [DATA_LEN-1:0] rem_q;
    logic [DATA_LEN-1:0] quo_q;
    logic [DATA_LEN-1:0] dvs_q;
    logic                qneg_q;
    logic                rneg_q;
    logic                div0_q;
    logic [DATA_LEN-1:0] rem_nx;
    logic [DATA_LEN-1:0] quo_nx;

    logic [DATA_LEN-1:0] quot_r;
    logic [DATA_LEN-1:0] rem_r;
    logic [TAG_W-1:0]    tag_r;
    logic                div0_r;

    div_step #(.DATA_LEN(DATA_LEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .dvs      (dvs_q),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        can_accept = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
        accept     = can_accept && bus.in_valid;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_PREP;
            ST_PREP: state_d = ST_ITER;
            ST_ITER: if (cnt == CNT_W'(1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = accept ? ST_PREP : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            tag_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            div0_q <= 1'b0;
            quot_r <= '0;
            rem_r  <= '0;
            tag_r  <= '0;
            div0_r <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= bus.in_a;
                b_q   <= bus.in_b;
                sgn_q <= bus.in_signed;
                tag_q <= bus.in_tag;
            end
            case (state_q)
                ST_PREP: begin
                    rem_q  <= '0;
                    quo_q  <= (sgn_q && a_q[DATA_LEN-1]) ? -a_q : a_q;
                    dvs_q  <= (sgn_q && b_q[DATA_LEN-1]) ? -b_q : b_q;
                    qneg_q <= sgn_q && (a_q[DATA_LEN-1] ^ b_q[DATA_LEN-1]);
                    rneg_q <= sgn_q && a_q[DATA_LEN-1];
                    div0_q <= (b_q == '0);
                    cnt    <= CNT_W'(DATA_LEN);
                end
                ST_ITER: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt   <= cnt - CNT_W'(1);
                end
                ST_FIX: begin
                    // a zero divisor returns the raw dividend, not its magnitude
                    quot_r <= div0_q ? '1  : (qneg_q ? -quo_q : quo_q);
                    rem_r  <= div0_q ? a_q : (rneg_q ? -rem_q : rem_q);
                    tag_r  <= tag_q;
                    div0_r <= div0_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = can_accept;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_quot  = quot_r;
    assign bus.out_rem   = rem_r;
    assign bus.out_tag   = tag_r;
    assign bus.out_div0  = div0_r;
    assign busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: arithmetic vectors, latency, backpressure, reset.
module tb_iter_divider;
    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   checks = 0;
    int   fails  = 0;

    iter_divider_if #(.DATA_LEN(32), .TAG_W(8)) bus ();

    iter_divider #(.DATA_LEN(32), .TAG_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Drive a request and return just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [7:0] tag, input logic ordy);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_signed = s;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        chk("in_ready_before_accept", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until out_valid, bounded.
    task automatic wait_result(input string name);
        int  n    = 0;
        bit  done = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.out_valid) done = 1;
        end
        chk({name, "_latency"}, 64'(n), 64'd34);
    endtask

    task automatic check_result(input string name, input logic [31:0] q, input logic [31:0] r,
                                input logic [7:0] tag, input logic d0);
        chk({name, "_quot"}, {32'd0, bus.out_quot}, {32'd0, q});
        chk({name, "_rem"},  {32'd0, bus.out_rem},  {32'd0, r});
        chk({name, "_tag"},  {56'd0, bus.out_tag},  {56'd0, tag});
        chk({name, "_div0"}, {63'd0, bus.out_div0}, {63'd0, d0});
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [7:0]  tag;
        logic [31:0] q;
        logic [31:0] r;
        logic        d0;
    } vec_t;

    vec_t vecs[$] = '{
        '{"u_100_7",      32'd100,        32'd7,          1'b0, 8'h11, 32'd14,         32'd2,          1'b0},
        '{"s_m100_7",     32'hFFFFFF9C,   32'd7,          1'b1, 8'h12, 32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0},
        '{"s_100_m7",     32'd100,        32'hFFFFFFF9,   1'b1, 8'h13, 32'hFFFFFFF2,   32'd2,          1'b0},
        '{"s_m100_m7",    32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 8'h14, 32'd14,         32'hFFFFFFFE,   1'b0},
        '{"u_5_0",        32'd5,          32'd0,          1'b0, 8'h15, 32'hFFFFFFFF,   32'd5,          1'b1},
        '{"s_m7_0",       32'hFFFFFFF9,   32'd0,          1'b1, 8'h16, 32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1},
        '{"s_minneg_m1",  32'h80000000,   32'hFFFFFFFF,   1'b1, 8'h17, 32'h80000000,   32'd0,          1'b0},
        '{"u_8000_ffff",  32'h80000000,   32'hFFFFFFFF,   1'b0, 8'h18, 32'd0,          32'h80000000,   1'b0},
        '{"u_ffff_ffff",  32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 8'h19, 32'd1,          32'd0,          1'b0}
    };

    initial begin
        logic [31:0] q_snap;
        logic [31:0] r_snap;
        bit          seen;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_signed = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_busy",      {63'd0, busy},          64'd0);
        chk("rst_quot",      {32'd0, bus.out_quot},  64'd0);
        chk("rst_tag",       {56'd0, bus.out_tag},   64'd0);

        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].tag, 1'b1);
            chk({vecs[i].name, "_busy"}, {63'd0, busy}, 64'd1);
            wait_result(vecs[i].name);
            check_result(vecs[i].name, vecs[i].q, vecs[i].r, vecs[i].tag, vecs[i].d0);
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_released"}, {63'd0, bus.out_valid}, 64'd0);
        end

        // Backpressure in DONE, with a request waiting that must not be taken early.
        send(32'd100, 32'd7, 1'b0, 8'h21, 1'b0);
        wait_result("bp");
        q_snap = bus.out_quot;
        r_snap = bus.out_rem;
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'd1000;
        bus.in_b      = 32'd10;
        bus.in_signed = 1'b0;
        bus.in_tag    = 8'h22;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("bp_valid",    {63'd0, bus.out_valid}, 64'd1);
            chk("bp_in_ready", {63'd0, bus.in_ready},  64'd0);
            chk("bp_quot",     {32'd0, bus.out_quot},  {32'd0, q_snap});
            chk("bp_rem",      {32'd0, bus.out_rem},   {32'd0, r_snap});
        end
        check_result("bp", 32'd14, 32'd2, 8'h21, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("b2b_prep_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("b2b_prep_busy",  {63'd0, busy},          64'd1);
        wait_result("b2b");
        check_result("b2b", 32'd100, 32'd0, 8'h22, 1'b0);
        @(posedge clk);
        #1;

        // Reset during ITER discards the in-flight request.
        send(32'd77, 32'd5, 1'b0, 8'h33, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst_busy",  {63'd0, busy},          64'd0);
        chk("midrst_quot",  {32'd0, bus.out_quot},  64'd0);
        chk("midrst_tag",   {56'd0, bus.out_tag},   64'd0);
        @(negedge clk);
        chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        chk("midrst_no_result", {63'd0, seen}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, the operand/result width (>=4).
REQ-002 SHALL have parameter TAG_W, default 8, the request tag width passed through unchanged.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request can be accepted this cycle.
REQ-007 SHALL have port in_a  input  DATA_LEN  dividend.
REQ-008 SHALL have port in_b  input  DATA_LEN  divisor.
REQ-009 SHALL have port in_signed  input  1  1 = two's-complement operation, 0 = unsigned.
REQ-010 SHALL have port in_tag  input  TAG_W  request tag.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have ports out_quot and out_rem  output  DATA_LEN each  quotient and remainder.
REQ-014 SHALL have port out_tag  output  TAG_W  tag of the request that produced the result.
REQ-015 SHALL have port out_div0  output  1  result came from a zero divisor.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement states IDLE, PREP, ITER, FIX, DONE.
REQ-018 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready).
REQ-019 SHALL accept a request on an edge where in_valid & in_ready, capture a, b, signed and tag, and enter PREP.
REQ-020 PREP (1 cycle) SHALL form operand magnitudes (absolute value when signed) and record quotient sign (sign(a) XOR sign(b)) and remainder sign (sign(a)).
REQ-021 ITER SHALL last exactly DATA_LEN cycles, one restoring shift-subtract step per cycle, with a counter of $clog2(DATA_LEN+1) bits.
REQ-022 FIX (1 cycle) SHALL apply sign corrections with DATA_LEN-bit wrap-around, then enter DONE.
REQ-023 Latency SHALL be fixed: out_valid rises DATA_LEN+2 cycles after the accepting edge, independent of operand values.
REQ-024 DONE SHALL hold out_valid=1 and all out_* stable until out_ready; on the out_ready edge go to PREP if a new request is accepted simultaneously, else IDLE.
REQ-025 Divisor zero SHALL give out_quot = all ones, out_rem = in_a, out_div0 = 1, same latency.
REQ-026 Signed most-negative / -1 SHALL give out_quot = most-negative value, out_rem = 0, out_div0 = 0.
REQ-027 out_div0 SHALL be 0 for every non-zero divisor.
REQ-028 in_valid while not in_ready SHALL be ignored (no capture, no state change).

Reset
REQ-029 reset SHALL force state IDLE, out_valid=0, out_quot=0, out_rem=0, out_tag=0, out_div0=0, counter=0, on the next edge, including mid-ITER or in DONE; any in-flight result is discarded.
REQ-030 The cycle after reset deasserts, in_ready SHALL be 1.

Structure
REQ-031 Shared package div_pkg SHALL hold the state enum t_div_state and the default DATA_LEN/TAG_W constants.
REQ-032 One combinational sub-module div_step SHALL implement a single restoring iteration (partial remainder, quotient bit), parametrised by DATA_LEN.

Verification (DATA_LEN=32)
REQ-033 Unsigned 100/7, tag 0x11 -> q=14, r=2, tag 0x11, div0=0, out_valid exactly 34 cycles after accept.
REQ-034 Signed -100/7 -> q=-14 (0xFFFFFFF2), r=-2 (0xFFFFFFFE); signed 100/-7 -> q=-14, r=2.
REQ-035 Unsigned 5/0 -> q=0xFFFFFFFF, r=5, div0=1; signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0, div0=0.
REQ-036 out_ready low 10 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 with in_valid=1 -> back-to-back accept, next result 34 cycles later.
REQ-037 reset asserted at ITER cycle 10 -> next cycle state IDLE, out_valid=0, busy=0; no result ever emitted for that request.
